wtm_pipe: RTL and testbench



---
 rtl/wtm_pkg.sv | 39 +++
 rtl/fulladder.sv | 11 +
 rtl/halfadder.sv | 10 +
 rtl/wtm_reduce.sv | 79 +++++++
 rtl/wtm_pipe.sv | 84 ++++++++
 tb/tb_wtm_pipe.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/wtm_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined Wallace-tree multiplier.
// WTM_LAT lets consumers delay side-band data to line up with prod.
package wtm_pkg;

   localparam int WTM_LAT   = 3;
   localparam int WTM_W_MIN = 4;
   localparam int WTM_W_MAX = 32;

   function automatic bit wtm_width_ok(input int w);
      return (w >= WTM_W_MIN) && (w <= WTM_W_MAX);
   endfunction

   // Rows remaining after s levels of 3:2 compression, starting from n rows.
   function automatic int wtm_rows(input int n, input int s);
      int r;
      r = n;
      for (int i = 0; i < s; i++) begin
         if (r > 2) r = 2 * (r / 3) + (r % 3);
      end
      return r;
   endfunction

   function automatic int wtm_levels(input int n);
      int s;
      s = 0;
      for (int i = 0; i < 16; i++) begin
         if (wtm_rows(n, s) > 2) s++;
      end
      return s;
   endfunction

   // Static occupancy of the initial matrix: rows 0..w-1 are shifted partial
   // products, row w holds the Baugh-Wooley correction constant.
   function automatic bit wtm_live(input int w, input int row, input int col);
      if (row < w) return (col >= row) && (col <= row + w - 1);
      return (col == w) || (col == 2 * w - 1);
   endfunction

endpackage

// File: rtl/fulladder.sv
// 3:2 compressor cell.
module fulladder (
   input  logic x,
   input  logic y,
   input  logic z,
   output logic s,
   output logic c
);
   assign s = x ^ y ^ z;
   assign c = (x & y) | (z & (x ^ y));
endmodule

// File: rtl/halfadder.sv
// 2:2 compressor cell.
module halfadder (
   input  logic x,
   input  logic y,
   output logic s,
   output logic c
);
   assign s = x ^ y;
   assign c = x & y;
endmodule

// File: rtl/wtm_reduce.sv
// Partial-product generation (plain or Baugh-Wooley) and Wallace reduction
// down to a sum row and a carry row, both truncated to 2W bits.
module wtm_reduce
   import wtm_pkg::*;
#(
   parameter int W = 8
) (
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   input  logic           is_signed,
   output logic [2*W-1:0] sum_row,
   output logic [2*W-1:0] carry_row
);

   localparam int N0 = W + 1;
   localparam int NL = wtm_levels(N0);
   localparam int P  = 2 * W;

   logic [P-1:0] m [NL+1][N0];

   for (genvar i = 0; i < W; i++) begin : g_pp
      logic [W-1:0] t;
      for (genvar j = 0; j < W; j++) begin : g_bit
         localparam bit INV = (i == W - 1) != (j == W - 1);
         if (INV) begin : g_inv
            assign t[j] = (a[j] & b[i]) ^ is_signed;
         end else begin : g_pos
            assign t[j] = a[j] & b[i];
         end
      end
      assign m[0][i] = P'(t) << i;
   end
   assign m[0][W] = is_signed ? ((P'(1) << W) | (P'(1) << (P - 1))) : '0;

   for (genvar s = 0; s < NL; s++) begin : g_lvl
      localparam int NI = wtm_rows(N0, s);
      localparam int NG = NI / 3;
      localparam int NO = wtm_rows(N0, s + 1);

      for (genvar g = 0; g < NG; g++) begin : g_csa
         logic [P-1:0] sv;
         logic [P-2:0] cv;
         // Level 0 knows which matrix bits are structurally zero; deeper levels do not.
         for (genvar j = 0; j < P - 1; j++) begin : g_col
            localparam bit L0 = (s != 0) || wtm_live(W, 3 * g, j);
            localparam bit L1 = (s != 0) || wtm_live(W, 3 * g + 1, j);
            localparam bit L2 = (s != 0) || wtm_live(W, 3 * g + 2, j);
            localparam int NLIVE = int'(L0) + int'(L1) + int'(L2);
            localparam int XA = L0 ? 3 * g : 3 * g + 1;
            localparam int YA = L2 ? 3 * g + 2 : 3 * g + 1;
            if (NLIVE == 3) begin : g_fa
               fulladder u_fa (
                  .x(m[s][3*g][j]), .y(m[s][3*g+1][j]), .z(m[s][3*g+2][j]),
                  .s(sv[j]), .c(cv[j])
               );
            end else if (NLIVE == 2) begin : g_ha
               halfadder u_ha (.x(m[s][XA][j]), .y(m[s][YA][j]), .s(sv[j]), .c(cv[j]));
            end else begin : g_wire
               assign sv[j] = m[s][3*g][j] | m[s][3*g+1][j] | m[s][3*g+2][j];
               assign cv[j] = 1'b0;
            end
         end
         assign sv[P-1] = m[s][3*g][P-1] ^ m[s][3*g+1][P-1] ^ m[s][3*g+2][P-1];
         assign m[s+1][2*g]     = sv;
         assign m[s+1][2*g + 1] = {cv, 1'b0};
      end

      for (genvar k = 0; k < NI - 3 * NG; k++) begin : g_pass
         assign m[s+1][2*NG + k] = m[s][3*NG + k];
      end
      for (genvar r = NO; r < N0; r++) begin : g_idle
         assign m[s+1][r] = '0;
      end
   end

   assign sum_row   = m[NL][0];
   assign carry_row = m[NL][1];

endmodule

// File: rtl/wtm_pipe.sv
// Three-stage streaming W x W multiplier: operand register, reduced sum/carry
// register, product register, each with its own valid and collapsing bubbles.
module wtm_pipe
   import wtm_pkg::*;
#(
   parameter int W = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   input  logic           is_signed,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*W-1:0] prod
);

   if (!wtm_width_ok(W)) begin : g_bad_width
      $error("wtm_pipe: W must lie in 4..32");
   end

   // Handshake: a transfer happens on a rising edge where valid && ready;
   // a producer holding valid keeps its data stable until that edge.
   logic           v1, v2, v3;
   logic           ld1, ld2, ld3;
   logic [W-1:0]   a1, b1;
   logic           sg1;
   logic [2*W-1:0] sum_n, car_n, sum2, car2, prod_n, prod3;

   assign ld3       = !v3 || out_ready;
   assign ld2       = !v2 || ld3;
   assign ld1       = !v1 || ld2;
   assign in_ready  = ld1;
   assign out_valid = v3;
   assign prod      = prod3;

   wtm_reduce #(.W(W)) u_reduce (
      .a         (a1),
      .b         (b1),
      .is_signed (sg1),
      .sum_row   (sum_n),
      .carry_row (car_n)
   );

   assign prod_n = sum2 + car2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
         v3 <= 1'b0;
      end else begin
         if (ld1) v1 <= in_valid;
         if (ld2) v2 <= v1;
         if (ld3) v3 <= v2;
      end
   end

   // Data only moves with a valid beat, so prod keeps its last result across bubbles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a1    <= '0;
         b1    <= '0;
         sg1   <= 1'b0;
         sum2  <= '0;
         car2  <= '0;
         prod3 <= '0;
      end else begin
         if (ld1 && in_valid) begin
            a1  <= a;
            b1  <= b;
            sg1 <= is_signed;
         end
         if (ld2 && v1) begin
            sum2 <= sum_n;
            car2 <= car_n;
         end
         if (ld3 && v2) prod3 <= prod_n;
      end
   end

endmodule

// File: tb/tb_wtm_pipe.sv
// Testbench for wtm_pipe: W=8 scenarios plus W=4/16/32 product sweeps.
module tb_wtm_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        in_valid, in_ready, is_signed, out_valid, out_ready;
   logic [7:0]  a, b;
   logic [15:0] prod;

   logic        iv4, ir4, s4, ov4;
   logic [3:0]  a4, b4;
   logic [7:0]  p4;
   logic        iv16, ir16, s16, ov16;
   logic [15:0] a16, b16;
   logic [31:0] p16;
   logic        iv32, ir32, s32, ov32;
   logic [31:0] a32, b32;
   logic [63:0] p32;

   int n_tests = 0;
   int n_fail  = 0;
   int n_out8  = 0, n_out4 = 0, n_out16 = 0, n_out32 = 0;

   logic [15:0] exp_q[$];
   logic [7:0]  q4[$];
   logic [31:0] q16[$];
   logic [63:0] q32[$];
   logic [15:0] e8;
   logic [7:0]  e4;
   logic [31:0] e16;
   logic [63:0] e32;

   wtm_pipe #(.W(8)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
      .is_signed(is_signed), .out_valid(out_valid), .out_ready(out_ready), .prod(prod)
   );
   wtm_pipe #(.W(4)) u_w4 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
      .is_signed(s4), .out_valid(ov4), .out_ready(1'b1), .prod(p4)
   );
   wtm_pipe #(.W(16)) u_w16 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
      .is_signed(s16), .out_valid(ov16), .out_ready(1'b1), .prod(p16)
   );
   wtm_pipe #(.W(32)) u_w32 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
      .is_signed(s32), .out_valid(ov32), .out_ready(1'b1), .prod(p32)
   );

   // Reference: sign-extend to 64 bits, multiply, keep the low 2w bits.
   function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                           input logic sg, input int w);
      logic [63:0] xe, ye, lo, mask;
      lo = (64'd1 << w) - 64'd1;
      xe = 64'(x) & lo;
      ye = 64'(y) & lo;
      if (sg && x[w-1]) xe = xe | ~lo;
      if (sg && y[w-1]) ye = ye | ~lo;
      mask = (w < 32) ? ((64'd1 << (2 * w)) - 64'd1) : '1;
      return (xe * ye) & mask;
   endfunction

   // Scoreboards: push on input handshake, pop and compare on output handshake.
   always @(negedge clk) begin
      if (rst_n) begin
         if (in_valid && in_ready) exp_q.push_back(16'(ref_mul(32'(a), 32'(b), is_signed, 8)));
         if (out_valid && out_ready) begin
            n_out8++;
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL sb8_extra: got %h, expected no output", prod);
            end else begin
               e8 = exp_q.pop_front();
               if (prod !== e8) begin
                  n_fail++;
                  $display("FAIL sb8_prod: got %h, expected %h", prod, e8);
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (iv4 && ir4) q4.push_back(8'(ref_mul(32'(a4), 32'(b4), s4, 4)));
         if (ov4) begin
            n_out4++;
            n_tests++;
            e4 = (q4.size() != 0) ? q4.pop_front() : ~p4;
            if (p4 !== e4) begin
               n_fail++;
               $display("FAIL sb4_prod: got %h, expected %h", p4, e4);
            end
         end
         if (iv16 && ir16) q16.push_back(32'(ref_mul(32'(a16), 32'(b16), s16, 16)));
         if (ov16) begin
            n_out16++;
            n_tests++;
            e16 = (q16.size() != 0) ? q16.pop_front() : ~p16;
            if (p16 !== e16) begin
               n_fail++;
               $display("FAIL sb16_prod: got %h, expected %h", p16, e16);
            end
         end
         if (iv32 && ir32) q32.push_back(ref_mul(a32, b32, s32, 32));
         if (ov32) begin
            n_out32++;
            n_tests++;
            e32 = (q32.size() != 0) ? q32.pop_front() : ~p32;
            if (p32 !== e32) begin
               n_fail++;
               $display("FAIL sb32_prod: got %h, expected %h", p32, e32);
            end
         end
      end
   end

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      n_tests++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b, expected 0", out_valid); end
      n_tests++;
      if (prod !== 16'h0) begin n_fail++; $display("FAIL reset_prod: got %h, expected 0000", prod); end
      n_tests++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b, expected 1", in_ready); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_latency();
      out_ready = 1'b1;
      a = 8'd255; b = 8'd255; is_signed = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      n_tests++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL lat_accept: in_ready %b, expected 1", in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         n_tests++;
         if (k < 3 && out_valid !== 1'b0) begin
            n_fail++; $display("FAIL lat_early: cycle %0d out_valid %b, expected 0", k, out_valid);
         end else if (k == 3 && (out_valid !== 1'b1 || prod !== 16'hFE01)) begin
            n_fail++; $display("FAIL lat_result: out_valid %b prod %h, expected 1 fe01", out_valid, prod);
         end
         @(posedge clk); #1;
      end
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_single: out_valid %b, expected 0", out_valid); end
      @(posedge clk); #1;
   endtask

   task automatic test_signed_corners();
      logic [7:0]  ca[3];
      logic [7:0]  cb[3];
      logic [15:0] cq[$];
      logic [15:0] ce;
      int idx, got;
      ca = '{8'h80, 8'hFF, 8'h7F};
      cb = '{8'h80, 8'h01, 8'h80};
      cq = '{16'h4000, 16'hFFFF, 16'hC080};
      idx = 0; got = 0;
      out_ready = 1'b1;
      for (int c = 0; c < 20 && got < 3; c++) begin
         if (idx < 3) begin
            a = ca[idx]; b = cb[idx]; is_signed = 1'b1; in_valid = 1'b1;
         end else in_valid = 1'b0;
         @(negedge clk);
         if (in_valid && in_ready) idx++;
         if (out_valid) begin
            got++;
            ce = cq.pop_front();
            n_tests++;
            if (prod !== ce) begin n_fail++; $display("FAIL signed_corner: got %h, expected %h", prod, ce); end
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      n_tests++;
      if (got != 3) begin n_fail++; $display("FAIL signed_count: got %0d results, expected 3", got); end
   endtask

   task automatic test_back_to_back();
      int sent, nout, first, last, stalls;
      sent = 0; nout = 0; first = -1; last = -1; stalls = 0;
      out_ready = 1'b1;
      for (int c = 0; c < 40 && nout < 16; c++) begin
         if (sent < 16) begin
            a = 8'($urandom_range(0, 255)); b = 8'($urandom_range(0, 255));
            is_signed = 1'($urandom_range(0, 1)); in_valid = 1'b1;
         end else in_valid = 1'b0;
         @(negedge clk);
         if (in_valid && !in_ready) stalls++;
         if (in_valid && in_ready) sent++;
         if (out_valid) begin
            nout++;
            if (first < 0) first = c;
            last = c;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      n_tests++;
      if (stalls != 0) begin n_fail++; $display("FAIL b2b_stall: %0d stalls, expected 0", stalls); end
      n_tests++;
      if (nout != 16) begin n_fail++; $display("FAIL b2b_count: got %0d results, expected 16", nout); end
      n_tests++;
      if (last - first != 15) begin n_fail++; $display("FAIL b2b_contig: span %0d, expected 15", last - first); end
   endtask

   task automatic test_backpressure();
      int acc_n, start;
      logic [15:0] held;
      bit accepted;
      acc_n = 0; accepted = 1'b1; held = '0;
      out_ready = 1'b0;
      for (int c = 0; c < 6; c++) begin
         if (accepted) begin
            a = 8'($urandom_range(0, 255)); b = 8'($urandom_range(0, 255));
            is_signed = 1'($urandom_range(0, 1));
         end
         in_valid = 1'b1;
         @(negedge clk);
         n_tests++;
         if (in_ready !== 1'(c < 3)) begin
            n_fail++; $display("FAIL bp_in_ready: cycle %0d got %b, expected %b", c, in_ready, c < 3);
         end
         accepted = in_valid && in_ready;
         if (accepted) acc_n++;
         if (c == 3) begin
            held = prod;
            n_tests++;
            if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_full: out_valid %b, expected 1", out_valid); end
         end
         if (c > 3) begin
            n_tests++;
            if (out_valid !== 1'b1 || prod !== held) begin
               n_fail++; $display("FAIL bp_hold: out_valid %b prod %h, expected 1 %h", out_valid, prod, held);
            end
         end
         @(posedge clk); #1;
      end
      n_tests++;
      if (acc_n != 3) begin n_fail++; $display("FAIL bp_accepts: got %0d, expected 3", acc_n); end
      in_valid = 1'b0;
      out_ready = 1'b1;
      start = n_out8;
      for (int k = 0; k < 10 && n_out8 - start < 3; k++) begin
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      n_tests++;
      if (n_out8 - start != 3) begin n_fail++; $display("FAIL bp_drain: got %0d results, expected 3", n_out8 - start); end
   endtask

   task automatic test_reset_midstream();
      int start;
      out_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         a = 8'($urandom_range(1, 127)); b = 8'($urandom_range(1, 127));
         is_signed = 1'b0; in_valid = 1'b1;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rst_pre_valid: got %b, expected 1", out_valid); end
      @(posedge clk); #1;
      #1 rst_n = 1'b0;
      #1;
      n_tests++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid: got %b, expected 0", out_valid); end
      n_tests++;
      if (prod !== 16'h0) begin n_fail++; $display("FAIL rst_mid_prod: got %h, expected 0000", prod); end
      exp_q.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      start = n_out8;
      repeat (6) begin
         @(posedge clk); #1;
      end
      n_tests++;
      if (n_out8 != start) begin n_fail++; $display("FAIL rst_ghost: got %0d results, expected 0", n_out8 - start); end
      a = 8'd12; b = 8'd11; is_signed = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int k = 0; k < 8 && n_out8 == start; k++) begin
         @(posedge clk); #1;
      end
      n_tests++;
      if (n_out8 - start != 1) begin n_fail++; $display("FAIL rst_first: got %0d results, expected 1", n_out8 - start); end
   endtask

   task automatic test_random();
      bit acc, stall_prev;
      logic [15:0] held;
      acc = 1'b0; stall_prev = 1'b0; held = '0;
      for (int c = 0; c < 300; c++) begin
         if (!in_valid || acc) begin
            a = 8'($urandom_range(0, 255)); b = 8'($urandom_range(0, 255));
            is_signed = 1'($urandom_range(0, 1));
            in_valid = ($urandom_range(0, 9) < 7);
         end
         out_ready = ($urandom_range(0, 9) < 6);
         @(negedge clk);
         if (stall_prev) begin
            n_tests++;
            if (out_valid !== 1'b1 || prod !== held) begin
               n_fail++; $display("FAIL rand_hold: out_valid %b prod %h, expected 1 %h", out_valid, prod, held);
            end
         end
         stall_prev = out_valid && !out_ready;
         held = prod;
         acc = in_valid && in_ready;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 20 && exp_q.size() != 0; k++) begin
         @(posedge clk); #1;
      end
      n_tests++;
      if (exp_q.size() != 0) begin n_fail++; $display("FAIL rand_drain: %0d results missing, expected 0", exp_q.size()); end
   endtask

   task automatic test_width_sweep();
      fork
         begin
            for (int i = 0; i < 512; i++) begin
               a4 = 4'(i); b4 = 4'(i >> 4); s4 = 1'(i >> 8); iv4 = 1'b1;
               @(negedge clk);
               for (int g = 0; g < 10 && !ir4; g++) @(negedge clk);
               @(posedge clk); #1;
            end
            iv4 = 1'b0;
         end
         begin
            for (int i = 0; i < 20000; i++) begin
               a16 = 16'($urandom_range(0, 65535)); b16 = 16'($urandom_range(0, 65535));
               s16 = (i >= 10000); iv16 = 1'b1;
               @(negedge clk);
               for (int g = 0; g < 10 && !ir16; g++) @(negedge clk);
               @(posedge clk); #1;
            end
            iv16 = 1'b0;
         end
         begin
            for (int i = 0; i < 20000; i++) begin
               a32 = $urandom(); b32 = $urandom();
               s32 = (i >= 10000); iv32 = 1'b1;
               @(negedge clk);
               for (int g = 0; g < 10 && !ir32; g++) @(negedge clk);
               @(posedge clk); #1;
            end
            iv32 = 1'b0;
         end
      join
      for (int k = 0; k < 20 && (q4.size() + q16.size() + q32.size()) != 0; k++) begin
         @(posedge clk); #1;
      end
      n_tests++;
      if (n_out4 != 512) begin n_fail++; $display("FAIL sweep4_count: got %0d, expected 512", n_out4); end
      n_tests++;
      if (n_out16 != 20000) begin n_fail++; $display("FAIL sweep16_count: got %0d, expected 20000", n_out16); end
      n_tests++;
      if (n_out32 != 20000) begin n_fail++; $display("FAIL sweep32_count: got %0d, expected 20000", n_out32); end
   endtask

   initial begin
      rst_n = 1'b0;
      in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; is_signed = 1'b0;
      iv4 = 1'b0; a4 = '0; b4 = '0; s4 = 1'b0;
      iv16 = 1'b0; a16 = '0; b16 = '0; s16 = 1'b0;
      iv32 = 1'b0; a32 = '0; b32 = '0; s32 = 1'b0;
      test_reset();
      test_latency();
      test_signed_corners();
      test_back_to_back();
      test_backpressure();
      test_reset_midstream();
      test_random();
      test_width_sweep();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1, "watchdog expired");
   end

endmodule
